// File: rtl/stream_mux_if.sv
// Valid/ready bundle between N producer streams, the stream_mux, and one consumer.
// The slave modport is the mux side; the master modport is the producer/consumer side.
interface stream_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) ();
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          select;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_channel;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  select,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_channel
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output select,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_channel
    );
endinterface

// File: rtl/stream_mux.sv
// N-to-1 valid/ready stream multiplexer with a registered output stage.
// MODE 0 forwards the software-selected channel; MODE 1 arbitrates round-robin.
module stream_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    stream_mux_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);
    // Index space padded to a power of two so out-of-range indices read as "not valid".
    localparam int SLOTS = 1 << SEL_W;

    logic [SLOTS-1:0] valid_pad;
    logic [WIDTH-1:0] words [SLOTS];
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load_en;
    logic             in_xfer;
    logic [SLOTS-1:0] ready_pad;

    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] channel_q;
    logic             valid_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_pad = '0;
        valid_pad[CHANNELS-1:0] = bus.in_valid;
        for (int i = 0; i < SLOTS; i++) begin
            words[i] = '0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            words[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    generate
        if (MODE == 0) begin : g_select
            always_comb begin
                grant       = bus.select;
                grant_valid = valid_pad[bus.select];
            end
        end else begin : g_round_robin
            logic [SEL_W-1:0] rr_ptr;

            // Search upward from rr_ptr, wrapping at CHANNELS-1; first valid channel wins.
            always_comb begin
                int idx;
                idx         = 0;
                grant       = '0;
                grant_valid = 1'b0;
                for (int k = 0; k < CHANNELS; k++) begin
                    idx = int'(rr_ptr) + k;
                    if (idx >= CHANNELS) begin
                        idx = idx - CHANNELS;
                    end
                    if (!grant_valid && valid_pad[SEL_W'(idx)]) begin
                        grant_valid = 1'b1;
                        grant       = SEL_W'(idx);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    rr_ptr <= '0;
                end else if (in_xfer) begin
                    rr_ptr <= (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
                end
            end
        end
    endgenerate

    assign load_en = !valid_q || bus.out_ready;
    assign in_xfer = reset_n && load_en && grant_valid;

    always_comb begin
        ready_pad = '0;
        if (in_xfer) begin
            ready_pad[grant] = 1'b1;
        end
    end

    assign bus.in_ready = ready_pad[CHANNELS-1:0];

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            channel_q <= '0;
        end else if (in_xfer) begin
            valid_q   <= 1'b1;
            data_q    <= words[grant];
            channel_q <= grant;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_data    = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_channel = channel_q;
endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: four instances cover both modes at 4 and 3 channels.
module tb_stream_mux;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;

    logic [7:0] words4 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] words3 [3] = '{8'h11, 8'h22, 8'h33};

    always #5 clk = ~clk;

    stream_mux_if #(.WIDTH(8), .CHANNELS(4)) if0 ();
    stream_mux_if #(.WIDTH(8), .CHANNELS(4)) if1 ();
    stream_mux_if #(.WIDTH(8), .CHANNELS(3)) if2 ();
    stream_mux_if #(.WIDTH(8), .CHANNELS(3)) if3 ();

    stream_mux #(.WIDTH(8), .CHANNELS(4), .MODE(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
    stream_mux #(.WIDTH(8), .CHANNELS(4), .MODE(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
    stream_mux #(.WIDTH(8), .CHANNELS(3), .MODE(0)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));
    stream_mux #(.WIDTH(8), .CHANNELS(3), .MODE(1)) dut3 (.clk(clk), .reset_n(reset_n), .bus(if3.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if0.in_data = 32'hDDCCBBAA; if0.in_valid = '0; if0.select = '0; if0.out_ready = 1'b0;
        if1.in_data = 32'hDDCCBBAA; if1.in_valid = '0; if1.select = '0; if1.out_ready = 1'b0;
        if2.in_data = 24'h332211;   if2.in_valid = '0; if2.select = '0; if2.out_ready = 1'b0;
        if3.in_data = 24'h332211;   if3.in_valid = '0; if3.select = '0; if3.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        if0.in_valid = 4'hF; if0.out_ready = 1'b1;
        if1.in_valid = 4'hF; if1.out_ready = 1'b1;
        reset_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (if1.in_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready_rr got=%b exp=0000", if1.in_ready); end
            total++; if (if0.in_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready_sel got=%b exp=0000", if0.in_ready); end
            total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if1.out_valid); end
            total++; if (if1.out_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", if1.out_data); end
            total++; if (if1.out_channel !== 2'd0) begin bad++; $display("FAIL rst_channel got=%0d exp=0", if1.out_channel); end
        end
        reset_n = 1'b1;
        #1;
        total++; if (if1.in_ready !== 4'b0001) begin bad++; $display("FAIL rst_first_grant got=%b exp=0001", if1.in_ready); end
        total++; if (if0.in_ready !== 4'b0001) begin bad++; $display("FAIL rst_first_sel got=%b exp=0001", if0.in_ready); end
        tick();
        total++; if (if1.out_valid !== 1'b1) begin bad++; $display("FAIL rst_load_valid got=%b exp=1", if1.out_valid); end
        total++; if (if1.out_channel !== 2'd0) begin bad++; $display("FAIL rst_load_channel got=%0d exp=0", if1.out_channel); end
        total++; if (if1.out_data !== 8'hAA) begin bad++; $display("FAIL rst_load_data got=%h exp=aa", if1.out_data); end
    endtask

    task automatic test_select();
        logic [3:0] exp_ready;
        do_reset();
        if0.in_valid = 4'hF;
        if0.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if0.select = 2'(k);
            #1;
            exp_ready = 4'b0001 << k;
            total++; if (if0.in_ready !== exp_ready) begin bad++; $display("FAIL sel_ready[%0d] got=%b exp=%b", k, if0.in_ready, exp_ready); end
            tick();
            total++; if (if0.out_data !== words4[k]) begin bad++; $display("FAIL sel_data[%0d] got=%h exp=%h", k, if0.out_data, words4[k]); end
            total++; if (if0.out_channel !== 2'(k)) begin bad++; $display("FAIL sel_channel[%0d] got=%0d exp=%0d", k, if0.out_channel, k); end
            total++; if (if0.out_valid !== 1'b1) begin bad++; $display("FAIL sel_valid[%0d] got=%b exp=1", k, if0.out_valid); end
        end
        if0.select = 2'd2;
        if0.in_valid = 4'b1011;
        #1;
        total++; if (if0.in_ready !== 4'b0000) begin bad++; $display("FAIL sel_invalid_ready got=%b exp=0000", if0.in_ready); end
        tick();
        total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL sel_drop_valid got=%b exp=0", if0.out_valid); end
        total++; if (if0.out_data !== 8'hDD) begin bad++; $display("FAIL sel_hold_data got=%h exp=dd", if0.out_data); end
    endtask

    task automatic test_round_robin();
        int         seq_all [6] = '{0, 1, 2, 3, 0, 1};
        int         seq_odd [4] = '{3, 1, 3, 1};
        logic [3:0] exp_ready;
        do_reset();
        if1.in_valid = 4'hF;
        if1.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_ready = 4'b0001 << seq_all[k];
            total++; if (if1.in_ready !== exp_ready) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, if1.in_ready, exp_ready); end
            tick();
            total++; if (if1.out_channel !== 2'(seq_all[k])) begin bad++; $display("FAIL rr_channel[%0d] got=%0d exp=%0d", k, if1.out_channel, seq_all[k]); end
            total++; if (if1.out_data !== words4[seq_all[k]]) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, if1.out_data, words4[seq_all[k]]); end
        end
        if1.in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_ready = 4'b0001 << seq_odd[k];
            total++; if (if1.in_ready !== exp_ready) begin bad++; $display("FAIL rr_odd_ready[%0d] got=%b exp=%b", k, if1.in_ready, exp_ready); end
            tick();
            total++; if (if1.out_channel !== 2'(seq_odd[k])) begin bad++; $display("FAIL rr_odd_channel[%0d] got=%0d exp=%0d", k, if1.out_channel, seq_odd[k]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        if0.in_valid = 4'hF;
        if0.select = 2'd1;
        if0.out_ready = 1'b1;
        tick();
        if0.out_ready = 1'b0;
        if0.select = 2'd2;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (if0.in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, if0.in_ready); end
            tick();
            total++; if (if0.out_data !== 8'hBB) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=bb", c, if0.out_data); end
            total++; if (if0.out_channel !== 2'd1) begin bad++; $display("FAIL bp_channel[%0d] got=%0d exp=1", c, if0.out_channel); end
            total++; if (if0.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, if0.out_valid); end
        end
        if0.out_ready = 1'b1;
        #1;
        total++; if (if0.in_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got=%b exp=0100", if0.in_ready); end
        tick();
        total++; if (if0.out_data !== 8'hCC) begin bad++; $display("FAIL bp_release_data got=%h exp=cc", if0.out_data); end
        total++; if (if0.out_channel !== 2'd2) begin bad++; $display("FAIL bp_release_channel got=%0d exp=2", if0.out_channel); end
        total++; if (if0.out_valid !== 1'b1) begin bad++; $display("FAIL bp_release_valid got=%b exp=1", if0.out_valid); end
    endtask

    task automatic test_drain_refill();
        do_reset();
        if0.in_valid = 4'hF;
        if0.select = 2'd3;
        if0.out_ready = 1'b1;
        tick();
        if0.in_valid = 4'b0000;
        total++; if (if0.out_valid !== 1'b1) begin bad++; $display("FAIL drain_loaded got=%b exp=1", if0.out_valid); end
        tick();
        total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", if0.out_valid); end
        total++; if (if0.out_data !== 8'hDD) begin bad++; $display("FAIL drain_data got=%h exp=dd", if0.out_data); end
        total++; if (if0.out_channel !== 2'd3) begin bad++; $display("FAIL drain_channel got=%0d exp=3", if0.out_channel); end
        total++; if (if0.in_ready !== 4'b0000) begin bad++; $display("FAIL drain_ready got=%b exp=0000", if0.in_ready); end
        if0.in_valid = 4'b1000;
        #1;
        total++; if (if0.in_ready !== 4'b1000) begin bad++; $display("FAIL refill_ready got=%b exp=1000", if0.in_ready); end
        tick();
        total++; if (if0.out_valid !== 1'b1) begin bad++; $display("FAIL refill_valid got=%b exp=1", if0.out_valid); end
    endtask

    task automatic test_non_pow2();
        int         seq3 [4] = '{0, 1, 2, 0};
        logic [2:0] exp_ready;
        do_reset();
        if2.in_valid = 3'b111;
        if2.select = 2'd3;
        if2.out_ready = 1'b1;
        #1;
        total++; if (if2.in_ready !== 3'b000) begin bad++; $display("FAIL np2_sel3_ready got=%b exp=000", if2.in_ready); end
        tick();
        total++; if (if2.out_valid !== 1'b0) begin bad++; $display("FAIL np2_sel3_valid got=%b exp=0", if2.out_valid); end
        if2.select = 2'd2;
        #1;
        total++; if (if2.in_ready !== 3'b100) begin bad++; $display("FAIL np2_sel2_ready got=%b exp=100", if2.in_ready); end
        tick();
        total++; if (if2.out_data !== 8'h33) begin bad++; $display("FAIL np2_sel2_data got=%h exp=33", if2.out_data); end

        if3.in_valid = 3'b111;
        if3.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_ready = 3'b001 << seq3[k];
            total++; if (if3.in_ready !== exp_ready) begin bad++; $display("FAIL np2_rr_ready[%0d] got=%b exp=%b", k, if3.in_ready, exp_ready); end
            tick();
            total++; if (if3.out_channel !== 2'(seq3[k])) begin bad++; $display("FAIL np2_rr_channel[%0d] got=%0d exp=%0d", k, if3.out_channel, seq3[k]); end
            total++; if (if3.out_data !== words3[seq3[k]]) begin bad++; $display("FAIL np2_rr_data[%0d] got=%h exp=%h", k, if3.out_data, words3[seq3[k]]); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_all();
        test_reset();
        test_select();
        test_round_robin();
        test_backpressure();
        test_drain_refill();
        test_non_pow2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-to-1 multiplexer for valid/ready data streams. It is the successor to the plain 2-to-1 bit mux. It generalises data width and channel count, adds a registered output stage with backpressure, and offers two modes: software-selected channel or round-robin arbitration. It sits between several producer streams and a single consumer, such as a shared bus port or output FIFO.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (>= 1)
- CHANNELS, 4, number of input channels (2..16; need not be a power of two)
- MODE, 0, 0 = select-driven, 1 = round-robin
- SEL_W (localparam), $clog2(CHANNELS), width of channel indices

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; one-hot or zero
- select  input  SEL_W  channel to forward in MODE 0; ignored in MODE 1
- out_data  output  WIDTH  registered output data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts when high with out_valid
- out_channel  output  SEL_W  index of the channel out_data came from

## Operation
- Input transfer on channel i: in_valid[i] && in_ready[i] at a rising edge. Output transfer: out_valid && out_ready.
- load_en = !out_valid || out_ready. The output register accepts a new word when it is empty or being drained in the same cycle.
- Grant, combinational from the current inputs and state:
  - MODE 0: grant = select if select < CHANNELS and in_valid[select]; otherwise no grant.
  - MODE 1: grant = first channel with in_valid set, searching upward from rr_ptr and wrapping at CHANNELS-1 → 0. No grant if all in_valid are 0.
- in_ready[i] = load_en && grant valid && grant == i. All other in_ready bits are 0.
  - in_ready never depends on the in_valid of another channel except through grant.
  - in_ready is 0 when no channel is valid.
- On an input transfer: out_data <= granted word, out_channel <= grant, out_valid <= 1.
- On an output transfer with no input transfer: out_valid <= 0. out_data and out_channel hold their last value.
- Output transfer and input transfer in the same cycle: the new word replaces the old one and out_valid stays 1. This gives full throughput.
- rr_ptr (MODE 1 only): on each input transfer, rr_ptr <= grant+1, wrapping to 0 after CHANNELS-1. Otherwise it holds. A channel that keeps in_valid high cannot starve the others.
- Stability: while out_valid && !out_ready, out_data, out_channel and out_valid hold unchanged.
- Reset (reset_n low at a rising edge): out_valid=0, out_data=0, out_channel=0, rr_ptr=0. All in_ready are 0 while reset_n is low. A word held in the output register is discarded.

## Timing
- Latency is 1 cycle from input transfer to out_valid.
- Throughput is 1 word per cycle when out_ready is held high.
- in_ready has a combinational path from out_valid, out_ready, in_valid, select and rr_ptr. There is no combinational path from any input to out_data, out_valid or out_channel.
- First cycle after reset_n rises: the register is empty, so in_ready reflects the grant immediately.
- A change of select takes effect in the same cycle for in_ready. It does not affect a word already in the output register.
- The consumer may deassert out_ready at any time. Producers must hold data and valid until their transfer completes; this block does not check that.

## Test plan
- Reset:
  - Stimulus: assert reset_n=0 for 2 cycles with all in_valid=1.
  - Response: out_valid=0, out_data=0, out_channel=0 and in_ready=0 throughout. After release, the first grant (MODE 1) goes to channel 0.
- MODE 0 select:
  - Setup: WIDTH=8, CHANNELS=4, in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA}, all valid, out_ready=1.
  - Stimulus: select 0,1,2,3 on consecutive cycles.
  - Response: out_data = AA, BB, CC, DD, each one cycle later, with out_channel 0..3.
  - Stimulus: select=2 with in_valid[2]=0.
  - Response: in_ready=0 and out_valid drops after the current word is drained.
- MODE 1 fairness:
  - Stimulus: all 4 valid continuously, out_ready=1.
  - Response: out_channel sequence 0,1,2,3,0,1. Each in_ready bit is high 1 cycle in 4.
  - Stimulus: only channels 1 and 3 valid.
  - Response: alternates 1,3,1,3.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with a word loaded.
  - Response: out_data and out_channel are stable, all in_ready=0, and no input transfer occurs. When out_ready=1, the next word loads in the same cycle and out_valid stays 1.
- Drain and refill:
  - Stimulus: a single word, then in_valid=0 and out_ready=1.
  - Response: out_valid falls the cycle after the output transfer. out_data holds its last value.
- Non-power-of-two:
  - Setup: CHANNELS=3, MODE 0.
  - Stimulus: select=3.
  - Response: no grant and in_ready=0.
  - Setup: CHANNELS=3, MODE 1.
  - Response: wraps 0,1,2,0.
